// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register of the MIPS core: latches ALU results and control,
// resolves branches, lane-aligns store data, builds byte enables, flags misalignment.
module ex_mem_latch #(
   parameter int BITS_SIZE = 32,
   parameter int BITS_REG  = 5,
   parameter int BITS_BE   = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_valid,
   input  logic [BITS_SIZE-1:0] i_alu_result,
   input  logic                 i_alu_zero,
   input  logic [BITS_SIZE-1:0] i_data_rt,
   input  logic [BITS_REG-1:0]  i_rd_addr,
   input  logic [BITS_SIZE-1:0] i_pc_plus4,
   input  logic [BITS_SIZE-1:0] i_pc_branch,
   input  logic                 i_reg_write,
   input  logic                 i_mem_read,
   input  logic                 i_mem_write,
   input  logic                 i_mem_to_reg,
   input  logic                 i_branch,
   input  logic                 i_branch_ne,
   input  logic                 i_jal,
   input  logic                 i_halt,
   input  logic [1:0]           i_width,
   input  logic                 i_unsigned,
   output logic                 o_valid,
   output logic [BITS_SIZE-1:0] o_result,
   output logic [BITS_SIZE-1:0] o_store_data,
   output logic [BITS_BE-1:0]   o_byte_en,
   output logic [BITS_REG-1:0]  o_rd_addr,
   output logic                 o_reg_write,
   output logic                 o_mem_read,
   output logic                 o_mem_write,
   output logic                 o_mem_to_reg,
   output logic                 o_unsigned,
   output logic [1:0]           o_width,
   output logic                 o_branch_taken,
   output logic [BITS_SIZE-1:0] o_pc_branch,
   output logic                 o_misaligned,
   output logic                 o_halt
);

   typedef struct packed {
      logic                 valid;
      logic [BITS_SIZE-1:0] result;
      logic [BITS_SIZE-1:0] store_data;
      logic [BITS_BE-1:0]   byte_en;
      logic [BITS_REG-1:0]  rd_addr;
      logic                 reg_write;
      logic                 mem_read;
      logic                 mem_write;
      logic                 mem_to_reg;
      logic                 unsigned_ld;
      logic [1:0]           width;
      logic                 branch_taken;
      logic [BITS_SIZE-1:0] pc_branch;
      logic                 misaligned;
      logic                 halt;
   } stage_t;

   stage_t stage_r;
   stage_t load_s;
   stage_t next_s;
   logic   misaligned_s;

   // Width code 2'b10 is treated as a word access everywhere below.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr);
      case (width)
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = addr[0];
         default: is_misaligned = (addr != 2'b00);
      endcase
   endfunction

   function automatic logic [BITS_SIZE-1:0] align_store(input logic [1:0] width,
                                                       input logic [BITS_SIZE-1:0] rt);
      case (width)
         2'b00:   align_store = {(BITS_SIZE/8){rt[7:0]}};
         2'b01:   align_store = {(BITS_SIZE/16){rt[15:0]}};
         default: align_store = rt;
      endcase
   endfunction

   function automatic logic [BITS_BE-1:0] byte_mask(input logic [1:0] width, input logic [1:0] addr);
      case (width)
         2'b00:   byte_mask = {{(BITS_BE-1){1'b0}}, 1'b1} << addr;
         2'b01:   byte_mask = addr[1] ? BITS_BE'(4'b1100) : BITS_BE'(4'b0011);
         default: byte_mask = {BITS_BE{1'b1}};
      endcase
   endfunction

   assign misaligned_s = i_valid & (i_mem_read | i_mem_write)
                       & is_misaligned(i_width, i_alu_result[1:0]);

   // Values captured on a normal load; an invalid instruction carries no control.
   always_comb begin
      load_s            = '0;
      load_s.valid      = i_valid;
      load_s.result     = i_jal ? i_pc_plus4 : i_alu_result;
      load_s.store_data = align_store(i_width, i_data_rt);
      load_s.rd_addr    = i_rd_addr;
      load_s.pc_branch  = i_pc_branch;
      load_s.halt       = stage_r.halt | (i_valid & i_halt);
      if (i_valid) begin
         load_s.reg_write    = i_reg_write & ~misaligned_s;
         load_s.mem_read     = i_mem_read & ~misaligned_s;
         load_s.mem_write    = i_mem_write & ~misaligned_s;
         load_s.mem_to_reg   = i_mem_to_reg;
         load_s.unsigned_ld  = i_unsigned;
         load_s.width        = i_width;
         load_s.branch_taken = (i_branch & i_alu_zero) | (i_branch_ne & ~i_alu_zero);
         load_s.misaligned   = misaligned_s;
         load_s.byte_en      = (i_mem_write & ~misaligned_s)
                             ? byte_mask(i_width, i_alu_result[1:0]) : '0;
      end else begin
         load_s.width = 2'b00;
      end
   end

   // Update priority: freeze > bubble > hold > load; a bubble keeps the sticky halt.
   always_comb begin
      next_s = stage_r;
      if (!i_enable) begin
         next_s = stage_r;
      end else if (i_flush) begin
         next_s      = '0;
         next_s.halt = stage_r.halt;
      end else if (i_stall) begin
         next_s = stage_r;
      end else begin
         next_s = load_s;
      end
   end

   // Stage register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         stage_r <= '0;
      end else begin
         stage_r <= next_s;
      end
   end

   assign o_valid        = stage_r.valid;
   assign o_result       = stage_r.result;
   assign o_store_data   = stage_r.store_data;
   assign o_byte_en      = stage_r.byte_en;
   assign o_rd_addr      = stage_r.rd_addr;
   assign o_reg_write    = stage_r.reg_write;
   assign o_mem_read     = stage_r.mem_read;
   assign o_mem_write    = stage_r.mem_write;
   assign o_mem_to_reg   = stage_r.mem_to_reg;
   assign o_unsigned     = stage_r.unsigned_ld;
   assign o_width        = stage_r.width;
   assign o_branch_taken = stage_r.branch_taken;
   assign o_pc_branch    = stage_r.pc_branch;
   assign o_misaligned   = stage_r.misaligned;
   assign o_halt         = stage_r.halt;

endmodule

// File: tb/tb_ex_mem_latch.sv
// Self-checking bench for ex_mem_latch: directed scenarios plus randomized
// traffic checked against a behavioural model of the EX/MEM stage.
module tb_ex_mem_latch;

   logic        i_clk = 1'b0;
   logic        i_reset, i_enable, i_stall, i_flush, i_valid;
   logic [31:0] i_alu_result, i_data_rt, i_pc_plus4, i_pc_branch;
   logic        i_alu_zero;
   logic [4:0]  i_rd_addr;
   logic        i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg;
   logic        i_branch, i_branch_ne, i_jal, i_halt, i_unsigned;
   logic [1:0]  i_width;
   logic        o_valid, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_unsigned;
   logic        o_branch_taken, o_misaligned, o_halt;
   logic [31:0] o_result, o_store_data, o_pc_branch;
   logic [3:0]  o_byte_en;
   logic [4:0]  o_rd_addr;
   logic [1:0]  o_width;

   int tests = 0;
   int failed = 0;

   // behavioural model state
   logic        m_valid, m_rw, m_mr, m_mw, m_m2r, m_uns, m_bt, m_mis, m_halt;
   logic [31:0] m_result, m_store, m_pcb;
   logic [3:0]  m_be;
   logic [4:0]  m_rd;
   logic [1:0]  m_width;
   logic        m_data_known;

   ex_mem_latch dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_stall(i_stall),
      .i_flush(i_flush), .i_valid(i_valid), .i_alu_result(i_alu_result),
      .i_alu_zero(i_alu_zero), .i_data_rt(i_data_rt), .i_rd_addr(i_rd_addr),
      .i_pc_plus4(i_pc_plus4), .i_pc_branch(i_pc_branch), .i_reg_write(i_reg_write),
      .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_to_reg(i_mem_to_reg),
      .i_branch(i_branch), .i_branch_ne(i_branch_ne), .i_jal(i_jal), .i_halt(i_halt),
      .i_width(i_width), .i_unsigned(i_unsigned),
      .o_valid(o_valid), .o_result(o_result), .o_store_data(o_store_data),
      .o_byte_en(o_byte_en), .o_rd_addr(o_rd_addr), .o_reg_write(o_reg_write),
      .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_mem_to_reg(o_mem_to_reg),
      .o_unsigned(o_unsigned), .o_width(o_width), .o_branch_taken(o_branch_taken),
      .o_pc_branch(o_pc_branch), .o_misaligned(o_misaligned), .o_halt(o_halt)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic rand_payload();
      i_valid      = 1'($urandom_range(0, 3) != 0);
      i_alu_result = $urandom;
      i_alu_zero   = 1'($urandom);
      i_data_rt    = $urandom;
      i_rd_addr    = 5'($urandom);
      i_pc_plus4   = $urandom;
      i_pc_branch  = $urandom;
      i_reg_write  = 1'($urandom);
      i_mem_read   = 1'($urandom);
      i_mem_write  = 1'($urandom);
      i_mem_to_reg = 1'($urandom);
      i_branch     = 1'($urandom);
      i_branch_ne  = 1'($urandom);
      i_jal        = 1'($urandom_range(0, 3) == 0);
      i_halt       = 1'($urandom_range(0, 15) == 0);
      i_width      = 2'($urandom);
      i_unsigned   = 1'($urandom);
   endtask

   task automatic quiet_payload();
      i_valid = 1'b0; i_alu_result = 32'd0; i_alu_zero = 1'b0; i_data_rt = 32'd0;
      i_rd_addr = 5'd0; i_pc_plus4 = 32'd0; i_pc_branch = 32'd0;
      i_reg_write = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_mem_to_reg = 1'b0;
      i_branch = 1'b0; i_branch_ne = 1'b0; i_jal = 1'b0; i_halt = 1'b0;
      i_width = 2'b00; i_unsigned = 1'b0;
      i_reset = 1'b0; i_enable = 1'b1; i_stall = 1'b0; i_flush = 1'b0;
   endtask

   task automatic model_clear(input logic keep_halt);
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_m2r = 0; m_uns = 0; m_bt = 0; m_mis = 0;
      m_result = 0; m_store = 0; m_pcb = 0; m_be = 0; m_rd = 0; m_width = 0;
      m_data_known = 1;
      if (!keep_halt) m_halt = 0;
   endtask

   // Applies the stage's rules to the inputs present at this clock edge.
   task automatic model_update();
      int addr, w;
      logic mis, mw;
      addr = int'(i_alu_result[1:0]);
      w    = (i_width == 2'b10) ? 3 : int'(i_width);
      if (i_reset) model_clear(1'b0);
      else if (!i_enable) begin end
      else if (i_flush) model_clear(1'b1);
      else if (i_stall) begin end
      else begin
         mis = i_valid && (i_mem_read || i_mem_write) &&
               ((w == 1 && addr % 2 != 0) || (w == 3 && addr != 0));
         mw  = i_valid && i_mem_write && !mis;
         m_valid = i_valid;
         m_data_known = i_valid;
         m_rw  = i_valid && i_reg_write && !mis;
         m_mr  = i_valid && i_mem_read && !mis;
         m_mw  = mw;
         m_m2r = i_valid && i_mem_to_reg;
         m_uns = i_valid && i_unsigned;
         m_bt  = i_valid && ((i_branch && i_alu_zero) || (i_branch_ne && !i_alu_zero));
         m_mis = mis;
         m_width  = i_width;
         m_result = i_jal ? i_pc_plus4 : i_alu_result;
         m_rd     = i_rd_addr;
         m_pcb    = i_pc_branch;
         if (w == 0) m_store = 32'(i_data_rt[7:0]) * 32'h0101_0101;
         else if (w == 1) m_store = 32'(i_data_rt[15:0]) * 32'h0001_0001;
         else m_store = i_data_rt;
         if (!mw) m_be = 4'd0;
         else if (w == 0) m_be = 4'(1 << addr);
         else if (w == 1) m_be = (addr >= 2) ? 4'd12 : 4'd3;
         else m_be = 4'd15;
         if (i_valid && i_halt) m_halt = 1;
      end
   endtask

   task automatic check_all();
      check_eq("valid", 32'(o_valid), 32'(m_valid));
      check_eq("reg_write", 32'(o_reg_write), 32'(m_rw));
      check_eq("mem_read", 32'(o_mem_read), 32'(m_mr));
      check_eq("mem_write", 32'(o_mem_write), 32'(m_mw));
      check_eq("mem_to_reg", 32'(o_mem_to_reg), 32'(m_m2r));
      check_eq("unsigned", 32'(o_unsigned), 32'(m_uns));
      check_eq("branch_taken", 32'(o_branch_taken), 32'(m_bt));
      check_eq("misaligned", 32'(o_misaligned), 32'(m_mis));
      check_eq("byte_en", 32'(o_byte_en), 32'(m_be));
      check_eq("halt", 32'(o_halt), 32'(m_halt));
      if (m_data_known) begin
         check_eq("width", 32'(o_width), 32'(m_width));
         check_eq("result", o_result, m_result);
         check_eq("store_data", o_store_data, m_store);
         check_eq("rd_addr", 32'(o_rd_addr), 32'(m_rd));
         check_eq("pc_branch", o_pc_branch, m_pcb);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      model_update();
      #1;
      check_all();
   endtask

   initial begin
      model_clear(1'b0);
      // reset held two cycles with random payload
      quiet_payload();
      rand_payload();
      i_reset = 1'b1; i_stall = 1'($urandom); i_flush = 1'($urandom);
      step();
      rand_payload();
      step();
      check_eq("rst_valid", 32'(o_valid), 32'd0);
      check_eq("rst_byte_en", 32'(o_byte_en), 32'd0);
      check_eq("rst_halt", 32'(o_halt), 32'd0);

      // sw word
      quiet_payload();
      i_valid = 1'b1; i_mem_write = 1'b1; i_width = 2'b11;
      i_alu_result = 32'h100; i_data_rt = 32'hDEADBEEF;
      step();
      check_eq("sw_data", o_store_data, 32'hDEADBEEF);
      check_eq("sw_be", 32'(o_byte_en), 32'hF);
      check_eq("sw_mis", 32'(o_misaligned), 32'd0);

      // sb at lane 3
      i_width = 2'b00; i_alu_result = 32'h103; i_data_rt = 32'h0000_00A5;
      step();
      check_eq("sb_data", o_store_data, 32'hA5A5A5A5);
      check_eq("sb_be", 32'(o_byte_en), 32'h8);

      // sh misaligned
      i_width = 2'b01; i_alu_result = 32'h101;
      step();
      check_eq("sh_mis", 32'(o_misaligned), 32'd1);
      check_eq("sh_mw", 32'(o_mem_write), 32'd0);
      check_eq("sh_be", 32'(o_byte_en), 32'd0);

      // beq taken, then three stalled cycles with new payload
      quiet_payload();
      i_valid = 1'b1; i_branch = 1'b1; i_alu_zero = 1'b1; i_pc_branch = 32'h40;
      step();
      check_eq("beq_taken", 32'(o_branch_taken), 32'd1);
      check_eq("beq_target", o_pc_branch, 32'h40);
      for (int k = 0; k < 3; k++) begin
         rand_payload();
         i_halt = 1'b0;
         i_stall = 1'b1;
         step();
         check_eq("stall_taken", 32'(o_branch_taken), 32'd1);
         check_eq("stall_target", o_pc_branch, 32'h40);
      end

      // flush with stall gives a bubble
      i_flush = 1'b1; i_stall = 1'b1;
      step();
      check_eq("flush_valid", 32'(o_valid), 32'd0);

      // load a valid op, then flush while disabled is ignored
      quiet_payload();
      i_valid = 1'b1; i_reg_write = 1'b1; i_alu_result = 32'h1234; i_rd_addr = 5'd7;
      step();
      i_enable = 1'b0; i_flush = 1'b1;
      step();
      check_eq("frozen_valid", 32'(o_valid), 32'd1);
      check_eq("frozen_result", o_result, 32'h1234);

      // jal writes the link value
      quiet_payload();
      i_valid = 1'b1; i_jal = 1'b1; i_reg_write = 1'b1; i_pc_plus4 = 32'h24;
      i_alu_result = 32'h999;
      step();
      check_eq("jal_result", o_result, 32'h24);

      // halt is sticky across bubbles until reset
      quiet_payload();
      i_valid = 1'b1; i_halt = 1'b1;
      step();
      check_eq("halt_set", 32'(o_halt), 32'd1);
      i_halt = 1'b0; i_flush = 1'b1;
      step();
      step();
      check_eq("halt_sticky", 32'(o_halt), 32'd1);
      i_flush = 1'b0; i_reset = 1'b1;
      step();
      check_eq("halt_reset", 32'(o_halt), 32'd0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rand_payload();
         i_reset  = 1'($urandom_range(0, 63) == 0);
         i_enable = 1'($urandom_range(0, 7) != 0);
         i_flush  = 1'($urandom_range(0, 7) == 0);
         i_stall  = 1'($urandom_range(0, 3) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
